alu_serial_seq: RTL

ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

---
 rtl/alu_serial_seq.sv | 89 ++++++++
 1 files changed

// File: rtl/alu_serial_seq.sv
// Bit-serial logic unit: streams operands LSB first through an external 1-bit
// logic slice and reassembles the slice outputs into a WIDTH-bit result.
module alu_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             slice_a,
    output logic             slice_b,
    output logic [1:0]       slice_s,
    input  logic             slice_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [1:0]       op_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;

    // Slice result enters at the MSB so that after WIDTH shifts bit 0 lands at acc[0].
    assign acc_next = {slice_out, acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= '0;
            cnt    <= '0;
            acc    <= '0;
            result <= '0;
            zero   <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        op_reg <= op;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end else begin
                        state  <= IDLE;
                    end
                end
                SHIFT: begin
                    acc   <= acc_next;
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    if (cnt == LAST_BIT) begin
                        // Counter parks on the last bit rather than wrapping.
                        result <= acc_next;
                        zero   <= (acc_next == '0);
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state == SHIFT);
    assign done    = (state == DONE);
    assign slice_a = busy ? a_reg[0] : 1'b0;
    assign slice_b = busy ? b_reg[0] : 1'b0;
    assign slice_s = busy ? op_reg   : 2'b00;

endmodule
